// File: rtl/vdp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vdp_pkg
// Description : Shared constants for the VDP interrupt sequencing logic:
//               active-line counts, status register selectors and the
//               default horizontal event sample point.
// Revision    : 1.0 - initial release
// ============================================================================
package vdp_pkg;

  // Line on which the V-blank event fires, selected by R#9 bit7
  localparam logic [9:0]  LINES_192 = 10'd192;
  localparam logic [9:0]  LINES_212 = 10'd212;

  // R#15 values that select S#0 (holds F) and S#1 (holds FH)
  localparam logic [3:0]  STATUS_S0 = 4'd0;
  localparam logic [3:0]  STATUS_S1 = 4'd1;

  // Horizontal position at which per-line events are sampled
  localparam logic [10:0] FLAG_SET_X_DEFAULT = 11'd1200;
  localparam logic [10:0] H_TOTAL_DEFAULT    = 11'd1368;

endpackage
`default_nettype wire

// File: rtl/vdp_interrupt_flag.sv
`default_nettype none
// ============================================================================
// Module      : vdp_interrupt_flag
// Description : One sticky interrupt flag. A set pulse takes priority over a
//               clear pulse in the same cycle; the enable only gates the
//               request output and never touches the stored flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vdp_interrupt_flag (
  input  logic clk,
  input  logic reset,
  input  logic i_set,
  input  logic i_clr,
  input  logic i_en,
  output logic o_flag,
  output logic o_irq
);

  logic r_flag;

  // Sticky flag: set wins over a coincident clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flag <= 1'b0;
    end else if (i_set) begin
      r_flag <= 1'b1;
    end else if (i_clr) begin
      r_flag <= 1'b0;
    end
  end

  assign o_flag = r_flag;
  assign o_irq  = r_flag & i_en;

endmodule
`default_nettype wire

// File: rtl/vdp_interrupt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vdp_interrupt_ctrl
// Description : VDP interrupt sequencing. Samples V-blank and line-match
//               events once per line at FLAG_SET_X, updates the F and FH
//               status flags, and drives the registered active-low
//               interrupt request to the slot.
// Revision    : 1.0 - initial release
// ============================================================================
module vdp_interrupt_ctrl
  import vdp_pkg::*;
#(
  parameter logic [10:0] FLAG_SET_X = FLAG_SET_X_DEFAULT,
  parameter logic [10:0] H_TOTAL    = H_TOTAL_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] h_count,
  input  logic [9:0]  v_count,
  input  logic        reg_ie0,
  input  logic        reg_ie1,
  input  logic        reg_ln,
  input  logic [7:0]  reg_il,
  input  logic [7:0]  reg_vscroll,
  input  logic        status_rd,
  input  logic [3:0]  status_sel,
  output logic        status_f,
  output logic        status_fh,
  output logic        intr_n
);

  logic       w_sample;
  logic [9:0] w_vblank_line;
  logic [7:0] w_line_sum;
  logic       w_line_match;
  logic       w_clr_f;
  logic       w_clr_fh;
  logic       w_irq_f;
  logic       w_irq_fh;
  logic       r_vblank_evt;
  logic       r_line_evt;
  logic       r_intr_n;

  // The sample point only counts while h_count is inside the line period
  assign w_sample      = (h_count == FLAG_SET_X) && (h_count < H_TOTAL);
  assign w_vblank_line = reg_ln ? LINES_212 : LINES_192;
  // 8-bit add: the scrolled line number wraps modulo 256
  assign w_line_sum    = v_count[7:0] + reg_vscroll;
  // Lines 256 and above (border/blanking) never produce a line match
  assign w_line_match  = (v_count[9:8] == 2'b00) && (w_line_sum == reg_il);

  // Stage 1: capture per-line event pulses; FH eligibility uses IE1 at sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vblank_evt <= 1'b0;
      r_line_evt   <= 1'b0;
    end else begin
      r_vblank_evt <= w_sample && (v_count == w_vblank_line);
      r_line_evt   <= w_sample && w_line_match && reg_ie1;
    end
  end

  // A status read clears only the flag held in the selected register
  assign w_clr_f  = status_rd && (status_sel == STATUS_S0);
  assign w_clr_fh = status_rd && (status_sel == STATUS_S1);

  vdp_interrupt_flag u_flag_f (
    .clk    (clk),
    .reset  (reset),
    .i_set  (r_vblank_evt),
    .i_clr  (w_clr_f),
    .i_en   (reg_ie0),
    .o_flag (status_f),
    .o_irq  (w_irq_f)
  );

  vdp_interrupt_flag u_flag_fh (
    .clk    (clk),
    .reset  (reset),
    .i_set  (r_line_evt),
    .i_clr  (w_clr_fh),
    .i_en   (reg_ie1),
    .o_flag (status_fh),
    .o_irq  (w_irq_fh)
  );

  // Stage 3: registered active-low request from the gated flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_intr_n <= 1'b1;
    end else begin
      r_intr_n <= ~(w_irq_f | w_irq_fh);
    end
  end

  assign intr_n = r_intr_n;

endmodule
`default_nettype wire
